fp_divider: RTL and testbench
=============================

FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port a, input, 32 bits: IEEE-754 single-precision dividend.
REQ-005 SHALL have port b, input, 32 bits: IEEE-754 single-precision divisor.
REQ-006 SHALL have port busy, output, 1 bit: high while an accepted operation is in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse marking result and flags valid.
REQ-008 SHALL have port result, output, 32 bits: quotient a/b.
REQ-009 SHALL have port overflow, output, 1 bit: exponent overflow flag.
REQ-010 SHALL have port underflow, output, 1 bit: exponent underflow flag.
REQ-011 SHALL have port div_by_zero, output, 1 bit: finite non-zero dividend with a zero divisor.
REQ-012 SHALL have port invalid, output, 1 bit: result is the canonical QNaN.

Function
REQ-013 SHALL classify each operand as follows: zero if exp==0 (denormals flushed, either sign); Inf if exp==255 and mant==0; NaN if exp==255 and mant!=0; otherwise normal.
REQ-014 SHALL latch a, b, the classification and sign = a[31]^b[31] on the edge where start=1 in IDLE.
REQ-015 SHALL ignore start while busy=1; latched operands SHALL NOT change mid-operation.
REQ-016 SHALL use the FSM states IDLE, DIV, NORM and DONE.
REQ-017 SHALL make these transitions:
- IDLE->DONE on start with any special operand;
- IDLE->DIV on start with two normal operands;
- DIV->NORM after 25 iterations;
- NORM->DONE;
- DONE->IDLE unconditionally.
REQ-018 SHALL resolve special cases with precedence top-down:
- any NaN, 0/0 or Inf/Inf -> 32'h7FC00000 with invalid=1;
- finite/0 -> {sign,8'hFF,23'h0} with div_by_zero=1;
- Inf/finite -> {sign,8'hFF,23'h0};
- 0/finite or finite/Inf -> {sign,31'h0}.
REQ-019 SHALL, in DIV, perform restoring division of ma={1,a[22:0]} by mb={1,b[22:0]}, one quotient bit per cycle, producing q = floor(ma*2^24/mb) (25 bits), using a 5-bit iteration counter.
REQ-020 SHALL compute the exponent in NORM as E = ea - eb + 127 in 10-bit signed arithmetic; the 8-bit fields SHALL never wrap.
REQ-021 SHALL normalise in NORM as follows: if q[24]=1, mant = q[23:1]; else mant = q[22:0] and E = E-1.
REQ-022 SHALL round by truncation (round toward zero); no guard, round or sticky bits.
REQ-023 SHALL, if E>=255, give result {sign,8'hFF,23'h0} with overflow=1.
REQ-024 SHALL, if E<=0, give result {sign,31'h0} with underflow=1.
REQ-025 SHALL otherwise give result {sign,E[7:0],mant}.
REQ-026 SHALL set busy=1 from the accepting edge until done falls, covering states DIV, NORM and DONE.
REQ-027 SHALL assert done in state DONE only, for exactly one cycle.
REQ-028 SHALL have a latency from the accepting edge to done=1 of 1 cycle for special operands and 27 cycles for normal operands.
REQ-029 SHALL update result and all four flags only on entry to DONE, and hold them until the next entry to DONE.
REQ-030 SHALL assert at most one flag per operation.
REQ-031 SHALL be able to accept start on the cycle after done (back-to-back operation).

Reset
REQ-032 SHALL, while rst_n=0, immediately force the FSM to IDLE and busy=0, done=0, result=32'h0, all flags=0, and counter and datapath registers to 0, regardless of clk.
REQ-033 SHALL, on reset mid-operation, abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-034 SHALL cover: a=32'h40C00000 (6.0), b=32'h40000000 (2.0) -> after 27 cycles done=1, result=32'h40400000, all flags 0.
REQ-035 SHALL cover: a=32'h3F800000, b=32'h40400000 -> result=32'h3EAAAAAA (truncated), latency 27.
REQ-036 SHALL cover: a=32'h3F800000, b=32'h00000000 -> after 1 cycle result=32'h7F800000, div_by_zero=1. Also a=32'h0, b=32'h0 -> result=32'h7FC00000, invalid=1.
REQ-037 SHALL cover: a=32'h7F000000, b=32'h00800000 -> result=32'h7F800000, overflow=1. Also a=32'h00800000, b=32'h7F000000 -> result=32'h0, underflow=1.
REQ-038 SHALL cover: start held high for 40 cycles -> exactly one accept per IDLE; the second operation begins the cycle after done; busy never drops mid-operation.
REQ-039 SHALL cover: rst_n pulsed low at iteration 10 of DIV -> outputs are 0 immediately, no done pulse, and the next start completes correctly.

Source files
------------

// File: rtl/fp_divider.sv
// Single-precision IEEE-754 divider: 25-cycle restoring mantissa division, truncating rounding,
// denormals flushed to zero and special operands resolved in a single cycle.
module fp_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero,
  output logic        invalid
);

  typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} state_e;

  state_e      state_q;
  logic        busy_q, done_q;
  logic [31:0] result_q;
  logic        ovf_q, unf_q, dbz_q, inv_q;
  logic        sign_q;
  logic [7:0]  ea_q, eb_q;
  logic [23:0] mb_q;
  logic [24:0] rem_q;
  logic [24:0] quo_q;
  logic [4:0]  cnt_q;

  // Operand classification on the live inputs; only consulted on the accepting edge.
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, in_special, in_sign;

  always_comb begin
    a_zero     = (a[30:23] == 8'h00);
    a_inf      = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    a_nan      = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_zero     = (b[30:23] == 8'h00);
    b_inf      = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    b_nan      = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    in_special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    in_sign    = a[31] ^ b[31];
  end

  logic [31:0] sp_res;
  logic        sp_dbz, sp_inv;

  always_comb begin
    sp_res = {in_sign, 31'h0};
    sp_dbz = 1'b0;
    sp_inv = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_res = 32'h7FC0_0000;
      sp_inv = 1'b1;
    end else if (b_zero && !a_inf) begin
      sp_res = {in_sign, 8'hFF, 23'h0};
      sp_dbz = 1'b1;
    end else if (a_inf) begin
      sp_res = {in_sign, 8'hFF, 23'h0};
    end
  end

  // One restoring step: remainder stays below 2*mb, so 25 bits suffice.
  logic        rem_ge;
  logic [24:0] rem_sub, rem_next;
  logic [24:0] quo_next;

  always_comb begin
    rem_ge   = (rem_q >= {1'b0, mb_q});
    rem_sub  = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_next = rem_sub << 1;
    quo_next = {quo_q[23:0], rem_ge};
  end

  logic signed [9:0] exp_raw, exp_n;
  logic [22:0]       mant;
  logic [31:0]       norm_res;
  logic              norm_ovf, norm_unf;

  always_comb begin
    exp_raw = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
    if (quo_q[24]) begin
      mant  = quo_q[23:1];
      exp_n = exp_raw;
    end else begin
      mant  = quo_q[22:0];
      exp_n = exp_raw - 10'sd1;
    end
    norm_res = {sign_q, exp_n[7:0], mant};
    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    if (exp_n >= 10'sd255) begin
      norm_res = {sign_q, 8'hFF, 23'h0};
      norm_ovf = 1'b1;
    end else if (exp_n <= 10'sd0) begin
      norm_res = {sign_q, 31'h0};
      norm_unf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      inv_q    <= 1'b0;
      sign_q   <= 1'b0;
      ea_q     <= 8'h0;
      eb_q     <= 8'h0;
      mb_q     <= 24'h0;
      rem_q    <= 25'h0;
      quo_q    <= 25'h0;
      cnt_q    <= 5'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_q <= 1'b1;
            sign_q <= in_sign;
            ea_q   <= a[30:23];
            eb_q   <= b[30:23];
            mb_q   <= {1'b1, b[22:0]};
            rem_q  <= {2'b01, a[22:0]};
            quo_q  <= 25'h0;
            cnt_q  <= 5'h0;
            if (in_special) begin
              result_q <= sp_res;
              ovf_q    <= 1'b0;
              unf_q    <= 1'b0;
              dbz_q    <= sp_dbz;
              inv_q    <= sp_inv;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end else begin
              state_q <= StDiv;
            end
          end
        end
        StDiv: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd24) state_q <= StNorm;
        end
        StNorm: begin
          result_q <= norm_res;
          ovf_q    <= norm_ovf;
          unf_q    <= norm_unf;
          dbz_q    <= 1'b0;
          inv_q    <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;
  assign invalid     = inv_q;

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: stimulus pushes expected results and done cycles,
// a negedge monitor pops and compares whenever done is seen.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] a, b;
  logic        busy, done, overflow, underflow, div_by_zero, invalid;
  logic [31:0] result;

  fp_divider dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .overflow   (overflow),
    .underflow  (underflow),
    .div_by_zero(div_by_zero),
    .invalid    (invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {overflow, underflow, div_by_zero, invalid}
    int          acc;
    int          done_cyc;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   spurious = 0;
  int   op_id = 0;
  bit   busy_gap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  // Cycle 1 is the one straight after the accepting edge.
  task automatic push_exp(input logic [31:0] r, input logic [3:0] f, input int acc, input int lat);
    exp_t x;
    x.res = r; x.flg = f; x.acc = acc; x.done_cyc = acc + lat - 1; x.id = op_id;
    op_id++;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && !busy && cyc >= sb[0].acc && cyc <= sb[0].done_cyc) busy_gap = 1'b1;
    if (done) begin
      if (sb.size() == 0) begin
        spurious++;
      end else begin
        e = sb.pop_front();
        chk($sformatf("op%0d result", e.id), 64'(result), 64'(e.res));
        chk($sformatf("op%0d flags", e.id),
            64'({overflow, underflow, div_by_zero, invalid}), 64'(e.flg));
        chk($sformatf("op%0d done cycle", e.id), 64'(cyc), 64'(e.done_cyc));
        chk($sformatf("op%0d busy held", e.id), 64'(busy_gap), 64'd0);
        busy_gap = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 80 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    chk("idle within budget", 64'(idle), 64'd1);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic [31:0] er,
                        input logic [3:0] ef, input int lat);
    int n;
    @(negedge clk);
    start = 1'b1; a = ta; b = tbv;
    @(posedge clk);
    #1;
    n = cyc;
    push_exp(er, ef, n, lat);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk($sformatf("op%0d hold", op_id - 1),
        64'({result, overflow, underflow, div_by_zero, invalid}), 64'({er, ef}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passes, checks);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; a = 32'h0; b = 32'h0;
    #12;
    chk("reset outputs", 64'({busy, done, result, overflow, underflow, div_by_zero, invalid}),
        64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27);  // 6/2
    run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 4'b0000, 27);  // 1/3 truncated
    run_op(32'h4000_0000, 32'h4080_0000, 32'h3F00_0000, 4'b0000, 27);  // 2/4
    run_op(32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000, 27);  // -6/2
    run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0010, 1);   // 1/0
    run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0001, 1);   // 0/0
    run_op(32'hC000_0000, 32'h8000_0000, 32'h7F80_0000, 4'b0010, 1);   // -2/-0
    run_op(32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, 4'b0010, 1);   // 1/denormal
    run_op(32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b0001, 1);   // NaN/1
    run_op(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b0001, 1);   // Inf/-Inf
    run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 1);   // -Inf/2
    run_op(32'h7F80_0000, 32'h8000_0000, 32'hFF80_0000, 4'b0000, 1);   // Inf/-0
    run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000, 1);   // -0/2
    run_op(32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000, 1);   // 2/-Inf
    run_op(32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 4'b0000, 1);   // denormal/2
    run_op(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 4'b1000, 27);  // overflow
    run_op(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 4'b0100, 27);  // underflow
    run_op(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 4'b0000, 27);  // E lands on 1
    run_op(32'h0080_0000, 32'h3FC0_0000, 32'h0000_0000, 4'b0100, 27);  // E drops to 0
    run_op(32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF, 4'b0000, 27);  // E lands on 254
    run_op(32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 4'b1000, 27);  // E reaches 255

    // start held for 40 cycles: second accept two edges after done's edge
    @(negedge clk);
    start = 1'b1; a = 32'h40C0_0000; b = 32'h4000_0000;
    @(posedge clk);
    #1;
    n = cyc;
    push_exp(32'h4040_0000, 4'b0000, n, 27);
    push_exp(32'h4040_0000, 4'b0000, n + 28, 27);
    repeat (39) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // reset around iteration 10 of DIV
    @(negedge clk);
    start = 1'b1; a = 32'h3F80_0000; b = 32'h4040_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset mid-op outputs",
        64'({busy, done, result, overflow, underflow, div_by_zero, invalid}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no done after abort", 64'(spurious), 64'd0);

    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27);

    repeat (3) @(negedge clk);
    chk("spurious done", 64'(spurious), 64'd0);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
